serial_mag_comp8: RTL
=====================

Name: serial_mag_comp8

Overview:
- Iterative 8-bit magnitude comparator for the 8-bit ALU compare path.
- Captures two operands, then walks them MSB-first one 2-bit slice per cycle through a 2-bit slice comparator.
- Accumulates the slice G/E/L results into a final A>B / A=B / A<B flag triple.
- Delivers that result over a valid/ready handshake to the ALU flag/result stage.

Parameters:
- WIDTH, 8, operand width; must be even and >= 2; slice count N = WIDTH/2.
- EARLY_EXIT, 0, when 1, finish on the first unequal slice; when 0, always scan all N slices.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands A/B present.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  operand A (unsigned).
- B  in  WIDTH  operand B (unsigned).
- out_valid  out  1  result flags valid.
- out_ready  in  1  consumer accepts result.
- G  out  1  A>B.
- E  out  1  A=B.
- L  out  1  A<B.
- busy  out  1  high in SCAN state.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE; in_ready=1; out_valid=0; busy=0; G=E=L=0.
  - Internal operand registers and slice index cleared.
  - Reset mid-SCAN or mid-HOLD aborts the operation and discards the result.
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, register A and B, set idx=N-1, set running flags to E (eq=1, gt=0, lt=0), go to SCAN.
  - SCAN: in_ready=0, busy=1. Each cycle, compare slice idx ({A[2idx+1],A[2idx]} vs {B[2idx+1],B[2idx]}) combinationally. At the clock edge:
    - If the slice is not equal and eq is still 1: latch gt/lt from the slice and clear eq. MSB dominates, so later slices never change a decided result.
    - If idx==0, or (EARLY_EXIT and the result is now decided): go to HOLD with G/E/L set from the flags.
    - Otherwise, idx decrements.
  - HOLD: out_valid=1. G/E/L are stable and exactly one-hot. On out_valid & out_ready, go to IDLE; out_valid=0 and in_ready=1 from the next cycle. There is no same-cycle turnaround.
- Latency, counted in rising edges after the acceptance edge:
  - EARLY_EXIT=0: out_valid after exactly N edges (4 for WIDTH=8), independent of data.
  - EARLY_EXIT=1: after k edges, where k is the 1-based position of the first unequal slice counted from the MSB; after N edges if all slices are equal.
- A/B changes after acceptance are ignored. in_valid while not in IDLE is ignored and must be held by the producer.
- G/E/L in IDLE/SCAN hold their previous values, and consumers qualify them with out_valid. They are 0 after reset.
- Throughput: one compare every N+2 cycles minimum (accept, N scan, handshake).

Decomposition:
- Shared ALU package:
  - constant SLICE_W=2;
  - typedef cmp_flags_t {g, e, l};
  - state encoding constants ST_IDLE, ST_SCAN, ST_HOLD.
- One natural sub-module: cmp_slice2, a combinational 2-bit comparator (a, b -> g, e, l). It is instantiated once and fed the currently selected slice.
- The FSM, index counter and flag accumulation live in the top.

Test Plan:
- Reset mid-SCAN: accept A=0xFF, B=0x00; pull rst_n low after 2 edges -> out_valid=0, in_ready=1, G=E=L=0 immediately; next accept of A=0x10, B=0x10 completes normally with E=1.
- EARLY_EXIT=0: A=0xA5, B=0xA5, out_ready=1 -> out_valid rises exactly 4 edges after acceptance with G=0, E=1, L=0; in_ready returns 1 one cycle after the handshake.
- EARLY_EXIT=0: A=0x80, B=0x7F -> G=1 after 4 edges. The lower slices of B are larger, but they must not override the MSB decision.
- EARLY_EXIT=1:
  - A=0x3C, B=0xC3 -> L=1 one edge after acceptance.
  - A=0x12, B=0x13 -> L=1 after 4 edges.
- Backpressure: A=0x01, B=0x00, out_ready=0 for 6 cycles -> out_valid and G=1 held stable, in_ready=0; operands on A/B during the stall are ignored; the result is consumed on the first out_ready=1.
- Exhaustive sweep: all 65536 A/B pairs, back-to-back, random out_ready -> G/E/L one-hot and match A>B / A==B / A<B every time.

Source files
------------

// File: rtl/serial_mag_comp8_pkg.sv
// Shared ALU compare definitions: slice width, flag triple and FSM states.
package serial_mag_comp8_pkg;

  localparam int SLICE_W = 2;

  // Greater / equal / less flag triple, exactly one-hot when meaningful.
  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } cmp_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } cmp_state_t;

endpackage

// File: rtl/serial_mag_comp8_cmp_slice2.sv
// Combinational 2-bit unsigned magnitude comparator.
module cmp_slice2
  import serial_mag_comp8_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  output cmp_flags_t         o_flags
);

  // Plain unsigned compare of one operand slice.
  always_comb begin
    o_flags.g = (i_a > i_b);
    o_flags.e = (i_a == i_b);
    o_flags.l = (i_a < i_b);
  end

endmodule

// File: rtl/serial_mag_comp8.sv
// Iterative magnitude comparator: captures A/B, scans 2-bit slices MSB-first,
// and returns a one-hot G/E/L result over a valid/ready handshake.
// WIDTH must be even and >= 2.
module serial_mag_comp8
  import serial_mag_comp8_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             G,
  output logic             E,
  output logic             L,
  output logic             busy
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  cmp_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  cmp_flags_t       r_run;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_g;
  logic             r_e;
  logic             r_l;

  logic [SLICE_W-1:0] w_sa;
  logic [SLICE_W-1:0] w_sb;
  cmp_flags_t         w_slice;
  cmp_flags_t         w_nxt;
  logic               w_done;

  // Select the slice addressed by the index counter from the captured operands.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < N; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sa = r_a[i*SLICE_W +: SLICE_W];
        w_sb = r_b[i*SLICE_W +: SLICE_W];
      end
    end
  end

  cmp_slice2 u_slice (
    .i_a     (w_sa),
    .i_b     (w_sb),
    .o_flags (w_slice)
  );

  // Fold the current slice into the running flags; once decided, MSB wins.
  always_comb begin
    w_nxt = r_run;
    if (r_run.e && !w_slice.e) begin
      w_nxt.e = 1'b0;
      w_nxt.g = w_slice.g;
      w_nxt.l = w_slice.l;
    end
    w_done = (r_idx == '0) || (EARLY_EXIT && !w_nxt.e);
  end

  // Control FSM with index counter, operand capture and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_run       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_g         <= 1'b0;
      r_e         <= 1'b0;
      r_l         <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= A;
            r_b        <= B;
            r_idx      <= IDX_TOP;
            r_run      <= '{g: 1'b0, e: 1'b1, l: 1'b0};
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_run <= w_nxt;
          if (w_done) begin
            r_g         <= w_nxt.g;
            r_e         <= w_nxt.e;
            r_l         <= w_nxt.l;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_HOLD;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign G         = r_g;
  assign E         = r_e;
  assign L         = r_l;

endmodule
